pa_fpu_wb_arb: RTL and testbench
================================

Name: pa_fpu_wb_arb

Overview:
- Writeback arbiter and scheduler for the FPU result bus (frbus).
- Shares the single frbus writeback slot between two requesters: the fixed-latency EX2 pipeline and the variable-latency FDSU (divide/sqrt).
- Guarantees the frbus sees at most one valid source per cycle. A colliding FDSU result is parked in a one-entry holding buffer.
- If the parked result waits too long, the block stalls EX1 issue until the result drains.

Parameters:
- MAX_WAIT, 3, cycles a buffered FDSU result may wait before the EX1 stall is asserted (range 1..15).
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- forever_cpuclk  input  1  block clock.
- cpurst_b  input  1  asynchronous active-low reset.
- ctrl_arb_ex2_wb_req  input  1  EX2 has a result this cycle; cannot be stalled.
- fdsu_arb_wb_req  input  1  FDSU result ready; held high with stable data until ack.
- fdsu_arb_data  input  32  FDSU result.
- fdsu_arb_fflags  input  5  FDSU exception flags.
- ctrl_arb_flush  input  1  pipeline flush; discards any FDSU result not yet written back.
- arb_fdsu_wb_ack  output  1  FDSU result accepted this cycle (written or buffered).
- arb_frbus_ex2_wb_req  output  1  EX2 granted the frbus.
- arb_frbus_fdsu_wb_vld  output  1  FDSU source granted the frbus.
- arb_frbus_fdsu_data  output  32  FDSU-source data to frbus.
- arb_frbus_fdsu_fflags  output  5  FDSU-source flags to frbus.
- arb_ctrl_ex1_stall  output  1  block new EX1 issue.
- arb_busy  output  1  buffer holds a pending result.

Behaviour:
- Clock and reset: one clock, forever_cpuclk. Reset is asynchronous and active-low, cpurst_b.
- Reset state:
  - FSM in IDLE, buffer invalid, data/flags 0, counter 0.
  - All outputs 0.
- Priority (combinational grant, same cycle): EX2 > buffer > live FDSU.
  - arb_frbus_ex2_wb_req = ctrl_arb_ex2_wb_req, passed through unmodified.
  - arb_frbus_fdsu_wb_vld = !ex2_req & (buf_vld | fdsu_req) & !flush.
  - Data mux selects the buffer when buf_vld, else the live fdsu_arb_* inputs.
  - When arb_frbus_fdsu_wb_vld = 0, arb_frbus_fdsu_data/fflags are driven to 0.
- FDSU acceptance:
  - buf empty, fdsu_req, no ex2_req: written directly. Ack = 1, buffer stays empty.
  - buf empty, fdsu_req, ex2_req: captured into the buffer on the clock edge. Ack = 1.
  - buf valid: ack = 0, live request not accepted. This preserves in-order FDSU results; the FDSU holds.
  - The drain cycle does not also accept a live request. The live request is accepted no earlier than the next cycle.
- FSM states:
  - IDLE: buf invalid.
  - HOLD: buf valid, counter < MAX_WAIT.
  - FORCE: buf valid, counter == MAX_WAIT.
- FSM transitions:
  - IDLE -> HOLD on capture; counter loads 1.
  - HOLD -> IDLE on drain (no ex2_req); counter clears.
  - HOLD, drain blocked: counter increments. On reaching MAX_WAIT the next state is FORCE.
  - FORCE -> IDLE on drain; FORCE holds otherwise.
  - Any state -> IDLE on flush. Flush has priority over capture and drain; flush also masks ack.
- Counter saturates at MAX_WAIT and never wraps.
- arb_ctrl_ex1_stall:
  - Registered: 1 in every cycle the state is FORCE, 0 otherwise.
  - EX2 requests already in flight (up to 2 cycles) still win. The buffer drains on the first cycle with no ex2_req.
- arb_busy = buf_vld, taken from the register.
- Reset asserted mid-operation: buffer and FSM cleared immediately; any pending FDSU result is lost. The FDSU is reset by the same cpurst_b.
- Invariant: arb_frbus_ex2_wb_req & arb_frbus_fdsu_wb_vld is never 1.

Decomposition:
- Shared package pa_fpu_pkg holds:
  - the state enum (IDLE/HOLD/FORCE, 2-bit encoding 00/01/10);
  - FPU_DATA_W = 32 and FPU_FLAG_W = 5;
  - a struct {data, fflags} for writeback payloads.
- One natural sub-module, pa_fpu_wb_buf: the one-entry holding register with valid, load/drain/flush controls.
- FSM, counter and grant logic live in the top.

Test Plan:
- Lone FDSU request: fdsu_req = 1, data = 0x3F800000, fflags = 5'h01, no ex2.
  - Same cycle: ack = 1, fdsu_wb_vld = 1, data out = 0x3F800000, busy stays 0.
- Collision: ex2_req and fdsu_req (data 0x40490FDB) in cycle 0.
  - Cycle 0: ex2 granted, ack = 1.
  - Cycle 1 (no ex2): fdsu_wb_vld = 1 with 0x40490FDB; busy falls in cycle 2.
- Starvation, MAX_WAIT = 3: capture in cycle 0, ex2_req held high in cycles 1-5.
  - State reaches FORCE in cycle 3; ex1_stall = 1 from cycle 3.
  - ex2 drops in cycle 6: drain in cycle 6, stall = 0 in cycle 7.
- Backpressure: buffer valid and a second fdsu_req.
  - ack = 0 until the buffer drains. The second result is granted one cycle after the drain cycle.
- Flush while buffer valid in FORCE:
  - Next cycle: IDLE, stall = 0, busy = 0, no fdsu_wb_vld.
  - A live fdsu_req during the flush cycle gets ack = 0.
- Async reset mid-HOLD: cpurst_b low between clock edges.
  - All outputs 0 immediately, without waiting for a clock edge.
  - Random 10k-cycle run: assert the one-hot invariant every cycle.

Source files
------------

// File: rtl/pa_fpu_pkg.sv
// Shared FPU types: writeback payload, arbiter FSM states and datapath widths.
package pa_fpu_pkg;

  localparam int FPU_DATA_W = 32;
  localparam int FPU_FLAG_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_FORCE = 2'b10
  } wb_state_e;

  typedef struct packed {
    logic [FPU_DATA_W-1:0] data;
    logic [FPU_FLAG_W-1:0] fflags;
  } wb_payload_t;

endpackage

// File: rtl/pa_fpu_wb_buf.sv
// One-entry holding register for an FDSU result that lost the frbus to EX2.
module pa_fpu_wb_buf
  import pa_fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_flush,
  input  wb_payload_t i_payload,
  output logic        o_vld,
  output wb_payload_t o_payload
);

  logic        r_vld;
  wb_payload_t r_payload;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld     <= 1'b0;
      // NOTE: the payload is reset too, so the parked result reads as zero
      // after reset instead of X in simulation.
      r_payload <= '0;
    end else begin
      if (i_flush || i_drain) begin
        r_vld <= 1'b0;
      end else if (i_load) begin
        r_vld <= 1'b1;
      end
      if (i_load && !i_flush) begin
        r_payload <= i_payload;
      end
    end
  end

  assign o_vld     = r_vld;
  assign o_payload = r_payload;

endmodule

// File: rtl/pa_fpu_wb_arb.sv
// frbus writeback arbiter: EX2 > parked FDSU result > live FDSU result, with
// an EX1 stall once a parked result has waited MAX_WAIT cycles.
module pa_fpu_wb_arb
  import pa_fpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  ctrl_arb_ex2_wb_req,
  input  logic                  fdsu_arb_wb_req,
  input  logic [FPU_DATA_W-1:0] fdsu_arb_data,
  input  logic [FPU_FLAG_W-1:0] fdsu_arb_fflags,
  input  logic                  ctrl_arb_flush,
  output logic                  arb_fdsu_wb_ack,
  output logic                  arb_frbus_ex2_wb_req,
  output logic                  arb_frbus_fdsu_wb_vld,
  output logic [FPU_DATA_W-1:0] arb_frbus_fdsu_data,
  output logic [FPU_FLAG_W-1:0] arb_frbus_fdsu_fflags,
  output logic                  arb_ctrl_ex1_stall,
  output logic                  arb_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wb_state_e   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic        r_stall;

  logic        w_buf_vld;
  wb_payload_t w_buf_payload;
  wb_payload_t w_live_payload;
  wb_payload_t w_out_payload;
  logic        w_ack;
  logic        w_load;
  logic        w_drain;
  logic        w_fdsu_vld;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_live_payload = '{data: fdsu_arb_data, fflags: fdsu_arb_fflags};

  // A parked result blocks live acceptance, including on its own drain cycle,
  // so FDSU results always reach the frbus in order.
  assign w_ack      = fdsu_arb_wb_req && !w_buf_vld && !ctrl_arb_flush;
  assign w_load     = w_ack && ctrl_arb_ex2_wb_req;
  assign w_drain    = w_buf_vld && !ctrl_arb_ex2_wb_req && !ctrl_arb_flush;
  assign w_fdsu_vld = !ctrl_arb_ex2_wb_req && (w_buf_vld || fdsu_arb_wb_req)
                      && !ctrl_arb_flush;
  assign w_cnt_inc  = r_cnt + CNT_ONE;

  pa_fpu_wb_buf u_wb_buf (
    .clk       (forever_cpuclk),
    .rst_n     (cpurst_b),
    .i_load    (w_load),
    .i_drain   (w_drain),
    .i_flush   (ctrl_arb_flush),
    .i_payload (w_live_payload),
    .o_vld     (w_buf_vld),
    .o_payload (w_buf_payload)
  );

  // NOTE: the zero default ahead of the branch keeps this purely
  // combinational; a path without an assignment would infer a latch.
  always_comb begin
    w_out_payload = '0;
    if (w_fdsu_vld) begin
      w_out_payload = w_buf_vld ? w_buf_payload : w_live_payload;
    end
  end

  // Stall is registered alongside the state so it is high exactly in FORCE.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else if (ctrl_arb_flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_cnt <= CNT_ONE;
            if (CNT_MAX == CNT_ONE) begin
              r_state <= ST_FORCE;
              r_stall <= 1'b1;
            end else begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_drain) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CNT_MAX) begin
              r_state <= ST_FORCE;
              r_stall <= 1'b1;
            end
          end
        end
        ST_FORCE: begin
          if (w_drain) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_stall <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign arb_fdsu_wb_ack       = w_ack;
  assign arb_frbus_ex2_wb_req  = ctrl_arb_ex2_wb_req;
  assign arb_frbus_fdsu_wb_vld = w_fdsu_vld;
  assign arb_frbus_fdsu_data   = w_out_payload.data;
  assign arb_frbus_fdsu_fflags = w_out_payload.fflags;
  assign arb_ctrl_ex1_stall    = r_stall;
  assign arb_busy              = w_buf_vld;

endmodule

// File: tb/tb_pa_fpu_wb_arb.sv
// Bench for pa_fpu_wb_arb: directed vector table, async reset sequence and a
// randomised run against a small behavioural model.
module tb_pa_fpu_wb_arb;

  localparam int MAX_WAIT = 3;

  logic        forever_cpuclk;
  logic        cpurst_b;
  logic        ctrl_arb_ex2_wb_req;
  logic        fdsu_arb_wb_req;
  logic [31:0] fdsu_arb_data;
  logic [4:0]  fdsu_arb_fflags;
  logic        ctrl_arb_flush;
  logic        arb_fdsu_wb_ack;
  logic        arb_frbus_ex2_wb_req;
  logic        arb_frbus_fdsu_wb_vld;
  logic [31:0] arb_frbus_fdsu_data;
  logic [4:0]  arb_frbus_fdsu_fflags;
  logic        arb_ctrl_ex1_stall;
  logic        arb_busy;

  int n_checks = 0;
  int n_fail   = 0;

  pa_fpu_wb_arb #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .forever_cpuclk        (forever_cpuclk),
    .cpurst_b              (cpurst_b),
    .ctrl_arb_ex2_wb_req   (ctrl_arb_ex2_wb_req),
    .fdsu_arb_wb_req       (fdsu_arb_wb_req),
    .fdsu_arb_data         (fdsu_arb_data),
    .fdsu_arb_fflags       (fdsu_arb_fflags),
    .ctrl_arb_flush        (ctrl_arb_flush),
    .arb_fdsu_wb_ack       (arb_fdsu_wb_ack),
    .arb_frbus_ex2_wb_req  (arb_frbus_ex2_wb_req),
    .arb_frbus_fdsu_wb_vld (arb_frbus_fdsu_wb_vld),
    .arb_frbus_fdsu_data   (arb_frbus_fdsu_data),
    .arb_frbus_fdsu_fflags (arb_frbus_fdsu_fflags),
    .arb_ctrl_ex1_stall    (arb_ctrl_ex1_stall),
    .arb_busy              (arb_busy)
  );

  initial forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  // Output bundle: {ack, ex2, vld, data[31:0], fflags[4:0], stall, busy}
  typedef struct {
    logic        ex2;
    logic        fdsu;
    logic        flush;
    logic [31:0] data;
    logic [4:0]  ff;
    logic [41:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ex2, input logic fdsu, input logic flush,
                              input logic [31:0] data, input logic [4:0] ff,
                              input logic e_ack, input logic e_ex2, input logic e_vld,
                              input logic [31:0] e_data, input logic [4:0] e_ff,
                              input logic e_stall, input logic e_busy);
    vec_t v;
    v.ex2   = ex2;
    v.fdsu  = fdsu;
    v.flush = flush;
    v.data  = data;
    v.ff    = ff;
    v.exp   = {e_ack, e_ex2, e_vld, e_data, e_ff, e_stall, e_busy};
    return v;
  endfunction

  function automatic logic [41:0] act_bundle();
    return {arb_fdsu_wb_ack, arb_frbus_ex2_wb_req, arb_frbus_fdsu_wb_vld,
            arb_frbus_fdsu_data, arb_frbus_fdsu_fflags, arb_ctrl_ex1_stall, arb_busy};
  endfunction

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ex2, input logic fdsu, input logic flush,
                       input logic [31:0] data, input logic [4:0] ff);
    ctrl_arb_ex2_wb_req = ex2;
    fdsu_arb_wb_req     = fdsu;
    ctrl_arb_flush      = flush;
    fdsu_arb_data       = data;
    fdsu_arb_fflags     = ff;
  endtask

  // Behavioural model state for the random run
  logic        m_buf;
  logic [31:0] m_data;
  logic [4:0]  m_ff;
  int          m_cnt;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'h0);
    cpurst_b = 1'b0;

    // Table: lone, collision, starvation with backpressure, flush in FORCE,
    // flush beating a capture.
    vecs.push_back(mk(0,0,0,32'h0,5'h00,        0,0,0,32'h0,5'h00,0,0));
    vecs.push_back(mk(0,1,0,32'h3F800000,5'h01, 1,0,1,32'h3F800000,5'h01,0,0));
    vecs.push_back(mk(1,0,0,32'h0,5'h00,        0,1,0,32'h0,5'h00,0,0));
    vecs.push_back(mk(1,1,0,32'h40490FDB,5'h10, 1,1,0,32'h0,5'h00,0,0));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,        0,0,1,32'h40490FDB,5'h10,0,1));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,        0,0,0,32'h0,5'h00,0,0));
    vecs.push_back(mk(1,1,0,32'hC0000000,5'h04, 1,1,0,32'h0,5'h00,0,0));
    vecs.push_back(mk(1,0,0,32'h0,5'h00,        0,1,0,32'h0,5'h00,0,1));
    vecs.push_back(mk(1,0,0,32'h0,5'h00,        0,1,0,32'h0,5'h00,0,1));
    vecs.push_back(mk(1,0,0,32'h0,5'h00,        0,1,0,32'h0,5'h00,1,1));
    vecs.push_back(mk(1,1,0,32'h11111111,5'h02, 0,1,0,32'h0,5'h00,1,1));
    vecs.push_back(mk(1,1,0,32'h11111111,5'h02, 0,1,0,32'h0,5'h00,1,1));
    vecs.push_back(mk(0,1,0,32'h11111111,5'h02, 0,0,1,32'hC0000000,5'h04,1,1));
    vecs.push_back(mk(0,1,0,32'h11111111,5'h02, 1,0,1,32'h11111111,5'h02,0,0));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,        0,0,0,32'h0,5'h00,0,0));
    vecs.push_back(mk(1,1,0,32'h22222222,5'h08, 1,1,0,32'h0,5'h00,0,0));
    vecs.push_back(mk(1,0,0,32'h0,5'h00,        0,1,0,32'h0,5'h00,0,1));
    vecs.push_back(mk(1,0,0,32'h0,5'h00,        0,1,0,32'h0,5'h00,0,1));
    vecs.push_back(mk(1,0,0,32'h0,5'h00,        0,1,0,32'h0,5'h00,1,1));
    vecs.push_back(mk(0,1,1,32'h33333333,5'h03, 0,0,0,32'h0,5'h00,1,1));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,        0,0,0,32'h0,5'h00,0,0));
    vecs.push_back(mk(1,1,1,32'h44444444,5'h1F, 0,1,0,32'h0,5'h00,0,0));
    vecs.push_back(mk(0,0,0,32'h0,5'h00,        0,0,0,32'h0,5'h00,0,0));

    #12;
    check("reset_state", act_bundle(), 42'h0);
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    @(posedge forever_cpuclk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].ex2, vecs[i].fdsu, vecs[i].flush, vecs[i].data, vecs[i].ff);
      @(negedge forever_cpuclk);
      check($sformatf("vec%0d", i), act_bundle(), vecs[i].exp);
      @(posedge forever_cpuclk);
      #1;
    end

    // Async reset mid-HOLD
    drive(1'b1, 1'b1, 1'b0, 32'h55555555, 5'h05);
    @(negedge forever_cpuclk);
    @(posedge forever_cpuclk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 5'h00);
    @(negedge forever_cpuclk);
    check("hold_before_reset", act_bundle(), {3'b010, 37'h0, 2'b01});
    #2;
    cpurst_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'h00);
    #1;
    check("async_reset_outputs", act_bundle(), 42'h0);
    #1;
    cpurst_b = 1'b1;
    @(negedge forever_cpuclk);
    check("after_reset_idle", act_bundle(), 42'h0);
    @(posedge forever_cpuclk);
    #1;

    // Randomised run against the model, with the one-hot grant invariant.
    m_buf  = 1'b0;
    m_data = '0;
    m_ff   = '0;
    m_cnt  = 0;
    begin
      logic        p_req;
      logic [31:0] p_data;
      logic [4:0]  p_ff;
      logic        r_ex2;
      logic        r_flush;
      logic        e_ack;
      logic        e_vld;
      logic [31:0] e_data;
      logic [4:0]  e_ff;
      logic        e_stall;
      p_req  = 1'b0;
      p_data = '0;
      p_ff   = '0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        if (!p_req && ($urandom_range(0, 2) == 0)) begin
          p_req  = 1'b1;
          p_data = $urandom;
          p_ff   = 5'($urandom_range(0, 31));
        end
        r_ex2   = ($urandom_range(0, 1) == 1);
        r_flush = ($urandom_range(0, 15) == 0);
        drive(r_ex2, p_req, r_flush, p_data, p_ff);
        @(negedge forever_cpuclk);

        e_ack   = p_req && !m_buf && !r_flush;
        e_vld   = !r_ex2 && (m_buf || p_req) && !r_flush;
        e_data  = e_vld ? (m_buf ? m_data : p_data) : 32'h0;
        e_ff    = e_vld ? (m_buf ? m_ff : p_ff) : 5'h0;
        e_stall = m_buf && (m_cnt == MAX_WAIT);
        check("onehot", {41'h0, arb_frbus_ex2_wb_req & arb_frbus_fdsu_wb_vld}, 42'h0);
        check($sformatf("rand%0d", cyc), act_bundle(),
              {e_ack, r_ex2, e_vld, e_data, e_ff, e_stall, m_buf});

        if (r_flush) begin
          m_buf = 1'b0;
          m_cnt = 0;
        end else if (m_buf && !r_ex2) begin
          m_buf = 1'b0;
          m_cnt = 0;
        end else if (m_buf) begin
          if (m_cnt < MAX_WAIT) m_cnt = m_cnt + 1;
        end else if (p_req && r_ex2) begin
          m_buf  = 1'b1;
          m_data = p_data;
          m_ff   = p_ff;
          m_cnt  = 1;
        end
        if (e_ack || r_flush) p_req = 1'b0;

        @(posedge forever_cpuclk);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
